// File: rtl/fp32_pkg.sv
// Shared types and constants for the binary32 dot-product engine.
package fp32_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_QNAN = 32'h7fc0_0000;

  typedef enum logic [0:0] {
    StAccum,
    StFlush
  } dot_state_e;

endpackage

// File: rtl/fp32_mac.sv
// Combinational fused multiply-add y = a*b + c in binary32 with a single
// round-to-nearest-even. Subnormal inputs read as zero, subnormal results flush
// to signed zero, and every NaN result is the canonical quiet NaN.
module fp32_mac
  import fp32_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  input  fp32_t c_i,
  output fp32_t y_o
);

  logic               sa, sb, sc, ps;
  logic               a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, any_nan;
  logic [23:0]        ma, mb, mc;
  logic [47:0]        prod;
  logic signed [11:0] ep, ec, emax, e_norm, e_rnd;
  logic [11:0]        diff;
  logic [5:0]         sh, lead;
  logic [50:0]        big, small_raw, small_sh;
  logic               big_s, small_s, sticky, res_s, rnd_inc;
  logic [52:0]        dif, dif_neg;
  logic [51:0]        mag, norm;
  logic [24:0]        mant;
  logic [22:0]        frac;

  // Align the addend against the exact 48-bit product, add, normalise, round.
  always_comb begin
    sa = a_i[31];
    sb = b_i[31];
    sc = c_i[31];
    ps = sa ^ sb;
    a_zero = (a_i[30:23] == 8'd0);
    b_zero = (b_i[30:23] == 8'd0);
    c_zero = (c_i[30:23] == 8'd0);
    a_inf  = (a_i[30:23] == 8'hff) && (a_i[22:0] == 23'd0);
    b_inf  = (b_i[30:23] == 8'hff) && (b_i[22:0] == 23'd0);
    c_inf  = (c_i[30:23] == 8'hff) && (c_i[22:0] == 23'd0);
    any_nan = ((a_i[30:23] == 8'hff) && (a_i[22:0] != 23'd0)) ||
              ((b_i[30:23] == 8'hff) && (b_i[22:0] != 23'd0)) ||
              ((c_i[30:23] == 8'hff) && (c_i[22:0] != 23'd0)) ||
              (a_inf && b_zero) || (b_inf && a_zero) ||
              ((a_inf || b_inf) && c_inf && (ps != sc));

    ma = a_zero ? 24'd0 : {1'b1, a_i[22:0]};
    mb = b_zero ? 24'd0 : {1'b1, b_i[22:0]};
    mc = c_zero ? 24'd0 : {1'b1, c_i[22:0]};
    prod = {24'd0, ma} * {24'd0, mb};

    // A zero operand is parked far below so it never pushes the other one out.
    ep = (a_zero || b_zero) ? -12'sd1024
                            : $signed({4'd0, a_i[30:23]}) + $signed({4'd0, b_i[30:23]}) - 12'sd127;
    ec = c_zero ? -12'sd1024 : $signed({4'd0, c_i[30:23]});

    // Both operands share the scale 2^(e-176); three guard bits sit below.
    if (ep >= ec) begin
      big       = {prod, 3'b000};
      big_s     = ps;
      small_raw = {1'b0, mc, 23'd0, 3'b000};
      small_s   = sc;
      emax      = ep;
      diff      = 12'(ep - ec);
    end else begin
      big       = {1'b0, mc, 23'd0, 3'b000};
      big_s     = sc;
      small_raw = {prod, 3'b000};
      small_s   = ps;
      emax      = ec;
      diff      = 12'(ec - ep);
    end
    sh       = (diff > 12'd51) ? 6'd51 : diff[5:0];
    sticky   = |(small_raw & ~({51{1'b1}} << sh));
    small_sh = (small_raw >> sh) | {50'd0, sticky};

    dif     = {2'b00, big} - {2'b00, small_sh};
    dif_neg = 53'd0 - dif;
    if (big_s == small_s) begin
      mag   = {1'b0, big} + {1'b0, small_sh};
      res_s = big_s;
    end else if (dif[52]) begin
      mag   = dif_neg[51:0];
      res_s = small_s;
    end else begin
      mag   = dif[51:0];
      res_s = big_s;
    end

    lead = 6'd0;
    for (int k = 0; k < 52; k++) begin
      if (mag[k]) lead = 6'(k);
    end
    norm    = mag << (6'd51 - lead);
    e_norm  = emax + $signed({6'd0, lead}) - 12'sd49;
    rnd_inc = norm[27] & ((|norm[26:0]) | norm[28]);
    mant    = {1'b0, norm[51:28]} + {24'd0, rnd_inc};
    e_rnd   = mant[24] ? e_norm + 12'sd1 : e_norm;
    frac    = mant[24] ? mant[23:1] : mant[22:0];

    if (any_nan)                y_o = FP32_QNAN;
    else if (a_inf || b_inf)    y_o = {ps, 8'hff, 23'd0};
    else if (c_inf)             y_o = {sc, 8'hff, 23'd0};
    else if (mag == 52'd0)      y_o = {ps & sc, 31'd0};
    else if (e_rnd >= 12'sd255) y_o = {res_s, 8'hff, 23'd0};
    else if (e_rnd <= 12'sd0)   y_o = {res_s, 31'd0};
    else                        y_o = {res_s, e_rnd[7:0], frac};
  end

endmodule

// File: rtl/fp32_dot_engine.sv
// Streaming binary32 dot-product engine: accumulates A*B pairs per vector and
// queues each finished sum in a first-word-fall-through result FIFO.
module fp32_dot_engine
  import fp32_pkg::*;
#(
  parameter int unsigned VEC_LEN   = 4,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic                        IN_VALID_I,
  output logic                        IN_READY_O,
  input  logic [31:0]                 IN_A_I,
  input  logic [31:0]                 IN_B_I,
  input  logic                        IN_LAST_I,
  input  logic                        ACC_KEEP_I,
  output logic                        OUT_VALID_O,
  input  logic                        OUT_READY_I,
  output logic [31:0]                 OUT_DATA_O,
  output logic [$clog2(OUT_DEPTH):0]  OUT_LEVEL_O
);

  localparam int unsigned CntW = $clog2(VEC_LEN + 1);
  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  dot_state_e      state_q, state_d;
  fp32_t           acc_q, acc_d, mac_y;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            keep_q, keep_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  fp32_t           mem_q [OUT_DEPTH];
  fp32_t           mem_d [OUT_DEPTH];
  logic            in_xfer, last_elem, fifo_full, push, pop;

  fp32_mac u_mac (
    .a_i (IN_A_I),
    .b_i (IN_B_I),
    .c_i (acc_q),
    .y_o (mac_y)
  );

  assign IN_READY_O  = (state_q == StAccum) && !RST_I;
  assign in_xfer     = IN_VALID_I && IN_READY_O;
  assign last_elem   = (cnt_q == CntW'(VEC_LEN - 1)) || IN_LAST_I;
  // Full is taken from the registered level, so a same-cycle pop cannot free a slot.
  assign fifo_full   = (level_q == LvlW'(OUT_DEPTH));
  assign push        = (state_q == StFlush) && !fifo_full;
  assign pop         = OUT_READY_I && (level_q != '0);
  assign OUT_VALID_O = (level_q != '0);
  assign OUT_DATA_O  = OUT_VALID_O ? mem_q[rd_ptr_q] : FP32_ZERO;
  assign OUT_LEVEL_O = level_q;

  // FSM next state: accumulate pairs, then flush the sum into the FIFO.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    keep_d  = keep_q;
    unique case (state_q)
      StAccum: begin
        if (in_xfer) begin
          acc_d = mac_y;
          if (last_elem) begin
            state_d = StFlush;
            keep_d  = ACC_KEEP_I;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StFlush: begin
        if (push) begin
          state_d = StAccum;
          if (!keep_q) acc_d = FP32_ZERO;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // FIFO next state; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = acc_q;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    level_d = level_q + LvlW'(push) - LvlW'(pop);
  end

  // Control state with synchronous reset.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= StAccum;
      acc_q    <= FP32_ZERO;
      cnt_q    <= '0;
      keep_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      keep_q   <= keep_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only visible below the level.
  always_ff @(posedge CLK_I) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fp32_dot_engine.sv
// Self-checking bench for fp32_dot_engine: directed scenarios plus random
// vectors scored against a double-precision reference model.
module tb_fp32_dot_engine;

  localparam int unsigned VecLen   = 4;
  localparam int unsigned OutDepth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        acc_keep = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_level;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fp32_dot_engine #(
    .VEC_LEN   (VecLen),
    .OUT_DEPTH (OutDepth)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .IN_VALID_I  (in_valid),
    .IN_READY_O  (in_ready),
    .IN_A_I      (in_a),
    .IN_B_I      (in_b),
    .IN_LAST_I   (in_last),
    .ACC_KEEP_I  (acc_keep),
    .OUT_VALID_O (out_valid),
    .OUT_READY_I (out_ready),
    .OUT_DATA_O  (out_data),
    .OUT_LEVEL_O (out_level)
  );

  // Reference: binary32 -> double is exact; a*b+c is exact in double for the
  // operand ranges used here, so one RNE rounding back to binary32 is the answer.
  function automatic real fp_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_fp(input real x);
    logic [63:0] d;
    logic [30:0] body;
    if (x == 0.0) return 32'd0;
    d    = $realtobits(x);
    body = {8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((|d[27:0]) || d[29])) body = body + 31'd1;
    return {d[63], body};
  endfunction

  function automatic logic [31:0] ref_mac(input logic [31:0] a, b, c);
    return real_to_fp(fp_to_real(a) * fp_to_real(b) + fp_to_real(c));
  endfunction

  // Random operand: magnitude in [0.25, 8), 12 significant bits.
  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom();
    e = 8'(125 + $urandom_range(0, 4));
    return {r[31], e, r[10:0], 12'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, b, input logic last, keep);
    int guard;
    guard    = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    acc_keep = keep;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_level !== 3'd0) begin
      n_bad++; $display("FAIL reset_fifo: valid=%b level=%0d want 0/0", out_valid, out_level);
    end
    n_cmp++;
    if (out_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) send(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL basic_flush_cycle: valid=%b ready=%b want 0/0", out_valid, in_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h41000000 || out_level !== 3'd1) begin
      n_bad++;
      $display("FAIL basic_result: valid=%b data=%h level=%0d want 1/41000000/1",
               out_valid, out_data, out_level);
    end
    pop_one();
    n_cmp++;
    if (out_level !== 3'd0) begin
      n_bad++; $display("FAIL basic_pop: level=%0d want 0", out_level);
    end
  endtask

  task automatic test_early_last();
    send(32'h40000000, 32'h40000000, 1'b0, 1'b0);
    send(32'h40400000, 32'h40000000, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h41200000) begin
      n_bad++; $display("FAIL early_last: valid=%b data=%h want 1/41200000", out_valid, out_data);
    end
    pop_one();
    for (int i = 0; i < 4; i++) send(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (out_data !== 32'h41000000) begin
      n_bad++; $display("FAIL early_restart: data=%h want 41000000", out_data);
    end
    pop_one();
  endtask

  task automatic test_keep();
    logic [31:0] want [3];
    logic        keeps [3];
    want  = '{32'h41000000, 32'h41800000, 32'h41000000};
    keeps = '{1'b1, 1'b0, 1'b0};
    for (int v = 0; v < 3; v++)
      for (int i = 0; i < 4; i++) send(32'h3F800000, 32'h40000000, 1'b0, keeps[v]);
    step();
    n_cmp++;
    if (out_level !== 3'd3) begin
      n_bad++; $display("FAIL keep_level: level=%0d want 3", out_level);
    end
    for (int v = 0; v < 3; v++) begin
      n_cmp++;
      if (out_data !== want[v]) begin
        n_bad++; $display("FAIL keep_result%0d: data=%h want %h", v, out_data, want[v]);
      end
      pop_one();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a_in [5];
    logic [31:0] want [5];
    a_in = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    want = '{32'h40800000, 32'h41000000, 32'h41400000, 32'h41800000, 32'h41A00000};
    out_ready = 1'b0;
    for (int v = 0; v < 5; v++)
      for (int i = 0; i < 4; i++) send(a_in[v], 32'h3F800000, 1'b0, 1'b0);
    step(); step(); step();
    n_cmp++;
    if (out_level !== 3'd4 || in_ready !== 1'b0 || out_data !== want[0]) begin
      n_bad++;
      $display("FAIL bp_full: level=%0d ready=%b data=%h want 4/0/%h",
               out_level, in_ready, out_data, want[0]);
    end
    pop_one();
    n_cmp++;
    if (out_level !== 3'd3 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_same_cycle_push: level=%0d ready=%b want 3/0", out_level, in_ready);
    end
    step();
    n_cmp++;
    if (out_level !== 3'd4 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_late_push: level=%0d ready=%b want 4/1", out_level, in_ready);
    end
    for (int v = 1; v < 5; v++) begin
      n_cmp++;
      if (out_data !== want[v]) begin
        n_bad++; $display("FAIL bp_order%0d: data=%h want %h", v, out_data, want[v]);
      end
      pop_one();
    end
    n_cmp++;
    if (out_level !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drained: level=%0d valid=%b want 0/0", out_level, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_level !== 3'd0) begin
      n_bad++; $display("FAIL reset_mid: valid=%b level=%0d want 0/0", out_valid, out_level);
    end
    for (int i = 0; i < 4; i++) send(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    step();
    n_cmp++;
    if (out_data !== 32'h41000000 || out_level !== 3'd1) begin
      n_bad++; $display("FAIL reset_mid_next: data=%h level=%0d want 41000000/1", out_data, out_level);
    end
    pop_one();
  endtask

  task automatic test_specials();
    send(32'h7F800000, 32'h00000000, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (out_data !== 32'h7FC00000) begin
      n_bad++; $display("FAIL inf_times_zero: data=%h want 7fc00000", out_data);
    end
    pop_one();
    send(32'hFF800000, 32'h3F800000, 1'b1, 1'b0);
    step();
    n_cmp++;
    if (out_data !== 32'hFF800000) begin
      n_bad++; $display("FAIL neg_inf: data=%h want ff800000", out_data);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    int          n_vec;
    int          got;
    int          budget;
    logic [31:0] acc_m;
    logic [31:0] want;
    n_vec  = 40;
    got    = 0;
    budget = 0;
    acc_m  = 32'd0;
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    fork
      begin
        int          len;
        logic        keep;
        logic        last;
        logic [31:0] a;
        logic [31:0] b;
        for (int v = 0; v < n_vec; v++) begin
          len  = $urandom_range(1, VecLen);
          keep = 1'($urandom_range(0, 1));
          for (int e = 0; e < len; e++) begin
            a    = rand_op();
            b    = rand_op();
            last = (e == len - 1);
            if ($urandom_range(0, 3) == 0) step();
            send(a, b, last && (len < VecLen || $urandom_range(0, 1) == 1), keep);
            acc_m = ref_mac(a, b, acc_m);
            if (last) begin
              exp_q.push_back(acc_m);
              if (!keep) acc_m = 32'd0;
            end
          end
        end
      end
      begin
        while (got < n_vec && budget < 20000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++; $display("FAIL b2b_extra: unexpected result %h", out_data);
            end else begin
              want = exp_q.pop_front();
              if (out_data !== want) begin
                n_bad++; $display("FAIL b2b_result%0d: data=%h want %h", got, out_data, want);
              end
            end
            got++;
          end
          step();
          budget++;
        end
        out_ready = 1'b0;
      end
    join
    step(); step(); step();
    n_cmp++;
    if (got != n_vec || exp_q.size() != 0 || out_level !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_count: got=%0d pending=%0d level=%0d want %0d/0/0",
               got, exp_q.size(), out_level, n_vec);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early_last();
    test_keep();
    test_backpressure();
    test_reset_mid();
    test_specials();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
